// File: rtl/fifo_drain_pkg.sv
// Shared types and defaults for the FIFO read-side drain engine.
package fifo_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned LEN_W_DEF  = 16;
    localparam int unsigned SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } drain_state_e;

endpackage

// File: rtl/fifo_drain_if.sv
// Command, FIFO read port and output stream of the drain engine; master is the engine side.
interface fifo_drain_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
);

    logic              cmd_valid;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_ready;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_empty;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;

    modport master (
        input  cmd_valid, cmd_len, fifo_rd_data, fifo_empty, out_ready,
        output cmd_ready, fifo_rd_en, out_valid, out_data, out_last
    );

    modport slave (
        output cmd_valid, cmd_len, fifo_rd_data, fifo_empty, out_ready,
        input  cmd_ready, fifo_rd_en, out_valid, out_data, out_last
    );

endinterface

// File: rtl/fifo_drain_skid.sv
// Two-entry pointer-based skid buffer absorbing the FIFO's one-cycle read latency.
module fifo_drain_skid
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [SKID_DEPTH];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              rd_ok;

    // A read against an empty buffer is ignored so a concurrent write lands at the head.
    always_comb begin
        rd_ok   = rd_en && (count != 2'd0);
        rd_data = mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(wr_en) - 2'(rd_ok);
        end
    end

endmodule

// File: rtl/fifo_drain.sv
// Drains a command-specified number of words from a synchronous FIFO onto a valid/ready stream.
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    fifo_drain_if.master bus,
    output logic         busy,
    output logic         done
);

    drain_state_e      state;
    logic [LEN_W-1:0]  rd_rem;
    logic [LEN_W-1:0]  dl_rem;
    logic              inflight;
    logic              pop;
    logic              rd_en;
    logic [1:0]        buf_cnt;
    logic [2:0]        occ;
    logic [DATA_W-1:0] head_data;

    // Occupancy after this cycle's pop must leave room for the word a new read brings.
    always_comb begin
        pop   = (buf_cnt != 2'd0) && bus.out_ready;
        occ   = 3'(buf_cnt) + 3'(inflight) - 3'(pop);
        rd_en = (state == RUN) && (rd_rem != '0) && !bus.fifo_empty
                && (occ < 3'(SKID_DEPTH));
    end

    always_comb begin
        bus.fifo_rd_en = rd_en;
        bus.out_valid  = (buf_cnt != 2'd0);
        bus.out_data   = head_data;
        bus.out_last   = (buf_cnt != 2'd0) && (dl_rem == LEN_W'(1));
    end

    fifo_drain_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (inflight),
        .wr_data (bus.fifo_rd_data),
        .rd_en   (pop),
        .rd_data (head_data),
        .count   (buf_cnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            rd_rem        <= '0;
            dl_rem        <= '0;
            inflight      <= 1'b0;
            bus.cmd_ready <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            inflight <= rd_en;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bus.cmd_ready <= 1'b0;
                        if (bus.cmd_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy   <= 1'b1;
                            rd_rem <= bus.cmd_len;
                            dl_rem <= bus.cmd_len;
                        end
                    end
                end
                RUN: begin
                    if (rd_en) begin
                        rd_rem <= rd_rem - LEN_W'(1);
                    end
                    if (pop) begin
                        dl_rem <= dl_rem - LEN_W'(1);
                        if (dl_rem == LEN_W'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    done          <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                end
                default: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    done          <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
